// File: rtl/seq_param_const_arb_if.sv
// Write-port bundle for seq_param_const_arb: two val/rdy requesters, restore,
// and the registered constant with its update pulse and write counter.
interface seq_param_const_arb_if #(
    parameter int nbits = 8
);
    logic             restore;
    logic             a_val;
    logic             a_rdy;
    logic [nbits-1:0] a_msg;
    logic             b_val;
    logic             b_rdy;
    logic [nbits-1:0] b_msg;
    logic [nbits-1:0] out;
    logic             upd;
    logic [3:0]       wr_count;

    // Requesters / configuration side.
    modport master (
        output restore, a_val, a_msg, b_val, b_msg,
        input  a_rdy, b_rdy, out, upd, wr_count
    );

    // Register side.
    modport slave (
        input  restore, a_val, a_msg, b_val, b_msg,
        output a_rdy, b_rdy, out, upd, wr_count
    );
endinterface

// File: rtl/seq_param_const_arb.sv
// Run-time overridable constant register with round-robin arbitrated writers.
// Optional macro SEQ_PARAM_CONST_ARB_LOCK_EN adds a combinational write lock.
module seq_param_const_arb #(
    parameter int nbits = 8,
    parameter     value = 8'hef
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef SEQ_PARAM_CONST_ARB_LOCK_EN
    input  logic                  lock,
`endif
    seq_param_const_arb_if.slave  bus
);

    localparam logic [nbits-1:0] VALUE = nbits'(value);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    pri_e             pri_q, pri_d;
    logic [nbits-1:0] out_q, out_d;
    logic             upd_q, upd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             lock_w;
    logic             blocked;
    logic             a_gnt, b_gnt;

`ifdef SEQ_PARAM_CONST_ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // Grants depend only on val, restore, lock, reset and the pointer.
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        blocked = reset || bus.restore || lock_w;
        if (!blocked) begin
            if (bus.a_val && bus.b_val) begin
                a_gnt = (pri_q == PRI_A);
                b_gnt = (pri_q == PRI_B);
            end else begin
                a_gnt = bus.a_val;
                b_gnt = bus.b_val;
            end
        end
    end

    always_comb begin
        pri_d = pri_q;
        out_d = out_q;
        cnt_d = cnt_q;
        upd_d = 1'b0;
        if (bus.restore) begin
            out_d = VALUE;
            upd_d = 1'b1;
        end else if (a_gnt) begin
            out_d = bus.a_msg;
            cnt_d = cnt_q + 4'd1;
            pri_d = PRI_B;
            upd_d = 1'b1;
        end else if (b_gnt) begin
            out_d = bus.b_msg;
            cnt_d = cnt_q + 4'd1;
            pri_d = PRI_A;
            upd_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q <= PRI_A;
            out_q <= VALUE;
            upd_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pri_q <= pri_d;
            out_q <= out_d;
            upd_q <= upd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.a_rdy    = a_gnt;
    assign bus.b_rdy    = b_gnt;
    assign bus.out      = out_q;
    assign bus.upd      = upd_q;
    assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_seq_param_const_arb.sv
// Directed bench for seq_param_const_arb: an 8-bit instance checked every
// cycle against a round-robin model, plus a 32-bit instance with literal checks.
module tb_seq_param_const_arb;

    localparam logic [7:0]  VAL8  = 8'hef;
    localparam logic [31:0] VAL32 = 32'hcafecafe;

    logic clk;
    logic reset;
    logic lock8;
    logic lock32;

    int n_tot;
    int n_bad;

    seq_param_const_arb_if #(.nbits(8))  bus8 ();
    seq_param_const_arb_if #(.nbits(32)) bus32 ();

    seq_param_const_arb #(.nbits(8), .value(8'hef)) dut8 (
        .clk   (clk),
        .reset (reset),
`ifdef SEQ_PARAM_CONST_ARB_LOCK_EN
        .lock  (lock8),
`endif
        .bus   (bus8)
    );

    seq_param_const_arb #(.nbits(32), .value(32'hcafecafe)) dut32 (
        .clk   (clk),
        .reset (reset),
`ifdef SEQ_PARAM_CONST_ARB_LOCK_EN
        .lock  (lock32),
`endif
        .bus   (bus32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: the requester that won most recently yields under contention.
    logic [7:0] m_out;
    logic       m_upd;
    int         m_cnt;
    logic       a_won_last;
    logic       exp_a, exp_b;

    always_comb begin
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (!reset && !bus8.restore && !lock8) begin
            if (bus8.a_val && bus8.b_val) begin
                exp_a = !a_won_last;
                exp_b = a_won_last;
            end else begin
                exp_a = bus8.a_val;
                exp_b = bus8.b_val;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_out      <= VAL8;
            m_upd      <= 1'b0;
            m_cnt      <= 0;
            a_won_last <= 1'b0;
        end else begin
            m_upd <= bus8.restore || exp_a || exp_b;
            if (bus8.restore) begin
                m_out <= VAL8;
            end else if (exp_a) begin
                m_out      <= bus8.a_msg;
                m_cnt      <= (m_cnt + 1) % 16;
                a_won_last <= 1'b1;
            end else if (exp_b) begin
                m_out      <= bus8.b_msg;
                m_cnt      <= (m_cnt + 1) % 16;
                a_won_last <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m.a_rdy",    64'(bus8.a_rdy),    64'(exp_a));
        chk("m.b_rdy",    64'(bus8.b_rdy),    64'(exp_b));
        chk("m.out",      64'(bus8.out),      64'(m_out));
        chk("m.upd",      64'(bus8.upd),      64'(m_upd));
        chk("m.wr_count", 64'(bus8.wr_count), 64'(m_cnt));
    end

    typedef struct {
        logic r;
        logic a;
        logic b;
    } vec_t;

    vec_t tbl[10];

    initial begin
        n_tot = 0;
        n_bad = 0;
        tbl[0] = '{1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1};

        reset  = 1'b1;
        lock8  = 1'b0;
        lock32 = 1'b0;
        bus8.restore  = 1'b0;
        bus8.a_val    = 1'b1;
        bus8.b_val    = 1'b1;
        bus8.a_msg    = '0;
        bus8.b_msg    = '0;
        bus32.restore = 1'b0;
        bus32.a_val   = 1'b0;
        bus32.b_val   = 1'b0;
        bus32.a_msg   = '0;
        bus32.b_msg   = '0;

        // Reset: requests are not granted while reset is high.
        @(negedge clk);
        chk("rst_a_rdy", 64'(bus8.a_rdy), 64'd0);
        chk("rst_b_rdy", 64'(bus8.b_rdy), 64'd0);
        cyc();
        bus8.a_val = 1'b0;
        bus8.b_val = 1'b0;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out",   64'(bus8.out),      64'hef);
        chk("rst_upd",   64'(bus8.upd),      64'd0);
        chk("rst_cnt",   64'(bus8.wr_count), 64'd0);
        chk("rst_out32", 64'(bus32.out),     64'hcafecafe);
        cyc();

        // Single A write.
        bus8.a_val = 1'b1;
        bus8.a_msg = 8'h12;
        @(negedge clk);
        chk("w12_a_rdy", 64'(bus8.a_rdy), 64'd1);
        cyc();
        bus8.a_val = 1'b0;
        @(negedge clk);
        chk("w12_out", 64'(bus8.out),      64'h12);
        chk("w12_upd", 64'(bus8.upd),      64'd1);
        chk("w12_cnt", 64'(bus8.wr_count), 64'd1);
        cyc();
        @(negedge clk);
        chk("w12_upd_drop", 64'(bus8.upd), 64'd0);

        // Contention from a fresh pointer: A,B,A,B.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus8.a_val = 1'b1;
        bus8.b_val = 1'b1;
        bus8.a_msg = 8'haa;
        bus8.b_msg = 8'hbb;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_a_rdy", 64'(bus8.a_rdy), (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k > 0)
                chk("rr_out", 64'(bus8.out), (k % 2 == 1) ? 64'haa : 64'hbb);
            cyc();
        end
        bus8.a_val = 1'b0;
        bus8.b_val = 1'b0;
        @(negedge clk);
        chk("rr_out_last", 64'(bus8.out),      64'hbb);
        chk("rr_cnt",      64'(bus8.wr_count), 64'd4);
        cyc();

        // Mixed table: restore under contention holds the pointer.
        for (int i = 0; i < 10; i++) begin
            bus8.restore = tbl[i].r;
            bus8.a_val   = tbl[i].a;
            bus8.b_val   = tbl[i].b;
            bus8.a_msg   = 8'h30 + 8'(i);
            bus8.b_msg   = 8'h40 + 8'(i);
            if (i == 2) begin
                @(negedge clk);
                chk("tbl_hold_b_rdy", 64'(bus8.b_rdy), 64'd1);
            end
            cyc();
        end
        bus8.restore = 1'b0;
        bus8.a_val   = 1'b0;
        bus8.b_val   = 1'b0;
        @(negedge clk);
        chk("tbl_out", 64'(bus8.out),      64'h49);
        chk("tbl_cnt", 64'(bus8.wr_count), 64'd11);
        cyc();

        // Write then restore while A still requests.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus8.a_val = 1'b1;
        bus8.a_msg = 8'h55;
        cyc();
        bus8.restore = 1'b1;
        @(negedge clk);
        chk("rs_a_rdy", 64'(bus8.a_rdy), 64'd0);
        chk("rs_out55", 64'(bus8.out),   64'h55);
        cyc();
        bus8.restore = 1'b0;
        bus8.a_val   = 1'b0;
        @(negedge clk);
        chk("rs_out", 64'(bus8.out),      64'hef);
        chk("rs_upd", 64'(bus8.upd),      64'd1);
        chk("rs_cnt", 64'(bus8.wr_count), 64'd1);
        cyc();

        // Counter wrap, then reset during a request.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus8.a_val = 1'b1;
            bus8.a_msg = 8'(i);
            cyc();
        end
        bus8.a_val = 1'b0;
        @(negedge clk);
        chk("wrap_cnt", 64'(bus8.wr_count), 64'd1);
        chk("wrap_out", 64'(bus8.out),      64'h10);
        bus8.b_val = 1'b1;
        bus8.b_msg = 8'h77;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus8.a_val = 1'b1;
        bus8.a_msg = 8'h66;
        @(negedge clk);
        chk("mr_out",   64'(bus8.out),      64'hef);
        chk("mr_cnt",   64'(bus8.wr_count), 64'd0);
        chk("mr_a_rdy", 64'(bus8.a_rdy),    64'd1);
        cyc();
        bus8.a_val = 1'b0;
        bus8.b_val = 1'b0;
        @(negedge clk);
        chk("mr_out66", 64'(bus8.out), 64'h66);
        cyc();

`ifdef SEQ_PARAM_CONST_ARB_LOCK_EN
        lock8 = 1'b1;
        bus8.a_val = 1'b1;
        bus8.a_msg = 8'h99;
        @(negedge clk);
        chk("lk_a_rdy", 64'(bus8.a_rdy), 64'd0);
        cyc();
        @(negedge clk);
        chk("lk_out", 64'(bus8.out),      64'h66);
        chk("lk_cnt", 64'(bus8.wr_count), 64'd1);
        chk("lk_upd", 64'(bus8.upd),      64'd0);
        bus8.restore = 1'b1;
        cyc();
        bus8.restore = 1'b0;
        lock8 = 1'b0;
        bus8.a_val = 1'b0;
        @(negedge clk);
        chk("lk_rs_out", 64'(bus8.out), 64'hef);
        chk("lk_rs_upd", 64'(bus8.upd), 64'd1);
        cyc();
`endif

        // 32-bit instance.
        bus32.b_val = 1'b1;
        bus32.b_msg = 32'hdeadbeef;
        @(negedge clk);
        chk("w32_b_rdy", 64'(bus32.b_rdy), 64'd1);
        cyc();
        bus32.b_val = 1'b0;
        @(negedge clk);
        chk("w32_out", 64'(bus32.out), 64'hdeadbeef);
        chk("w32_cnt", 64'(bus32.wr_count), 64'd1);
`ifdef SEQ_PARAM_CONST_ARB_LOCK_EN
        lock32 = 1'b1;
        bus32.a_val = 1'b1;
        bus32.a_msg = 32'h01234567;
        @(negedge clk);
        chk("lk32_a_rdy", 64'(bus32.a_rdy), 64'd0);
        cyc();
        @(negedge clk);
        chk("lk32_out", 64'(bus32.out), 64'hdeadbeef);
        lock32 = 1'b0;
        bus32.a_val = 1'b0;
`endif
        cyc();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
